cmd_ctrl: RTL
=============

CMD_CTRL -- requirements
Module: cmd_ctrl

Interface
REQ-001 Parameter DATAWIDTH, default 8, byte width of RX, register file and FIFO data.
REQ-002 Parameter ADDRWIDTH, default 4, register-file address width.
REQ-003 CLK  input  1  single clock; all logic on rising edge.
REQ-004 RST  input  1  synchronous, active-low reset.
REQ-005 RX_P_DATA  input  DATAWIDTH  synchronized received byte from the UART receive path.
REQ-006 RX_D_VLD  input  1  one-cycle pulse; RX_P_DATA valid.
REQ-007 RF_ADDR  output  ADDRWIDTH  register-file address.
REQ-008 RF_WR_EN / RF_RD_EN  output  1 each  one-cycle write and read strobes.
REQ-009 RF_WR_DATA  output  DATAWIDTH  register-file write data.
REQ-010 RF_RD_DATA  input  DATAWIDTH; RF_RD_VLD  input  1  read data and its valid pulse.
REQ-011 ALU_EN  output  1; ALU_FUN  output  4  ALU enable (level) and function code.
REQ-012 ALU_OUT  input  2*DATAWIDTH; ALU_OUT_VLD  input  1  ALU result and its valid pulse.
REQ-013 CLK_GATE_EN  output  1  ALU clock-gate enable.
REQ-014 FIFO_WR_DATA  output  DATAWIDTH; FIFO_WR_INC  output  1; FIFO_FULL  input  1  transmit-FIFO write port.

Function
REQ-015 Frames are byte sequences on RX_D_VLD: 0xAA addr data (RF write); 0xBB addr (RF read); 0xCC opA opB fun (ALU with operands); 0xDD fun (ALU, no operands).
REQ-016 States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_SEND, OPA, OPB, FUN, ALU_WAIT, SEND_LO, SEND_HI.
REQ-017 IDLE: byte 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->OPA, 0xDD->FUN; any other byte discarded, stay IDLE.
REQ-018 WR_ADDR: on byte, latch RF_ADDR = byte[ADDRWIDTH-1:0] (upper bits ignored) ->WR_DATA.
REQ-019 WR_DATA: on byte, RF_WR_EN=1 and RF_WR_DATA=byte in the next cycle for exactly one cycle ->IDLE.
REQ-020 RD_ADDR: on byte, RF_ADDR=byte, RF_RD_EN=1 for one cycle ->RD_WAIT; RD_WAIT holds until RF_RD_VLD, latching RF_RD_DATA ->RD_SEND.
REQ-021 OPA / OPB: on byte, one-cycle RF write to address 0 (OPA) or 1 (OPB) with that byte; OPA->OPB, OPB->FUN.
REQ-022 FUN: on byte, ALU_FUN=byte[3:0], ALU_EN=1, CLK_GATE_EN=1 ->ALU_WAIT; ALU_EN holds until ALU_OUT_VLD, which latches ALU_OUT and drops ALU_EN ->SEND_LO.
REQ-023 CLK_GATE_EN=1 in FUN-accept cycle through ALU_WAIT only; 0 otherwise.
REQ-024 RD_SEND/SEND_LO/SEND_HI: if FIFO_FULL=0, FIFO_WR_INC=1 for one cycle with FIFO_WR_DATA = read byte / ALU_OUT[7:0] / ALU_OUT[15:8]; SEND_LO->SEND_HI, others->IDLE.
REQ-025 FIFO_FULL=1 in a send state: no write, stay, data held stable; write in first cycle FULL=0.
REQ-026 RX_D_VLD in RD_WAIT, ALU_WAIT or any send state: byte dropped, no state change.
REQ-027 RF_RD_VLD / ALU_OUT_VLD outside their wait state: ignored.
REQ-028 Strobes never overlap: at most one of RF_WR_EN, RF_RD_EN, FIFO_WR_INC high per cycle.
REQ-029 All outputs registered; no combinational path input->output.

Reset
REQ-030 RST=0 at a rising edge: state IDLE; all outputs 0 (RF_ADDR, RF_WR_DATA, ALU_FUN, FIFO_WR_DATA = 0; all strobes and enables 0); latched data cleared.
REQ-031 Reset mid-frame aborts the frame with no further strobes; partial frame is not resumed.

Verification
REQ-032 Write: AA,05,3C -> one RF_WR_EN pulse, RF_ADDR=5, RF_WR_DATA=0x3C; no FIFO write.
REQ-033 Read: BB,02; RF_RD_VLD with 0x7E three cycles later -> one RF_RD_EN, RF_ADDR=2, one FIFO_WR_INC with 0x7E.
REQ-034 ALU: CC,0A,03,00; ALU_OUT=0x000D -> writes addr0=0x0A, addr1=0x03; ALU_FUN=0; FIFO bytes 0x0D then 0x00; CLK_GATE_EN low afterwards.
REQ-035 Backpressure: DD,02, ALU_OUT=0x1234, FIFO_FULL=1 for 5 cycles -> no FIFO_WR_INC while full, then 0x34, 0x12.
REQ-036 Junk/reset: byte 0x55 in IDLE -> no activity; RST=0 after AA,05 -> no RF write; following AA,01,FF performs a normal write.

Source files
------------

// File: rtl/cmd_ctrl_if.sv
// Bus bundle between the command controller and its register file, ALU and transmit FIFO.
// The master modport is the controller; the slave modport is the peripheral side.
interface cmd_ctrl_if #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 4
);
    // Receive path
    logic [DATAWIDTH-1:0]   RX_P_DATA;
    logic                   RX_D_VLD;

    // Register file
    logic [ADDRWIDTH-1:0]   RF_ADDR;
    logic                   RF_WR_EN;
    logic                   RF_RD_EN;
    logic [DATAWIDTH-1:0]   RF_WR_DATA;
    logic [DATAWIDTH-1:0]   RF_RD_DATA;
    logic                   RF_RD_VLD;

    // ALU
    logic                   ALU_EN;
    logic [3:0]             ALU_FUN;
    logic [2*DATAWIDTH-1:0] ALU_OUT;
    logic                   ALU_OUT_VLD;
    logic                   CLK_GATE_EN;

    // Transmit FIFO
    logic [DATAWIDTH-1:0]   FIFO_WR_DATA;
    logic                   FIFO_WR_INC;
    logic                   FIFO_FULL;

    modport master (
        input  RX_P_DATA, RX_D_VLD,
        input  RF_RD_DATA, RF_RD_VLD,
        input  ALU_OUT, ALU_OUT_VLD,
        input  FIFO_FULL,
        output RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA,
        output ALU_EN, ALU_FUN, CLK_GATE_EN,
        output FIFO_WR_DATA, FIFO_WR_INC
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD,
        output RF_RD_DATA, RF_RD_VLD,
        output ALU_OUT, ALU_OUT_VLD,
        output FIFO_FULL,
        input  RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA,
        input  ALU_EN, ALU_FUN, CLK_GATE_EN,
        input  FIFO_WR_DATA, FIFO_WR_INC
    );
endinterface

// File: rtl/cmd_ctrl.sv
// Command frame decoder: parses received bytes into register-file writes/reads and ALU
// operations, and returns read data / ALU results through the transmit FIFO.
module cmd_ctrl #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 4
) (
    input  logic         CLK,
    input  logic         RST,
    cmd_ctrl_if.master   bus
);

    localparam logic [DATAWIDTH-1:0] OP_RF_WR  = DATAWIDTH'(8'hAA);
    localparam logic [DATAWIDTH-1:0] OP_RF_RD  = DATAWIDTH'(8'hBB);
    localparam logic [DATAWIDTH-1:0] OP_ALU_OP = DATAWIDTH'(8'hCC);
    localparam logic [DATAWIDTH-1:0] OP_ALU_NO = DATAWIDTH'(8'hDD);

    localparam logic [ADDRWIDTH-1:0] OPA_ADDR = ADDRWIDTH'(0);
    localparam logic [ADDRWIDTH-1:0] OPB_ADDR = ADDRWIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_RD_SEND,
        S_OPA,
        S_OPB,
        S_FUN,
        S_ALU_WAIT,
        S_SEND_LO,
        S_SEND_HI
    } state_t;

    state_t                 state_q;
    logic [ADDRWIDTH-1:0]   rf_addr_q;
    logic                   rf_wr_en_q;
    logic                   rf_rd_en_q;
    logic [DATAWIDTH-1:0]   rf_wr_data_q;
    logic                   alu_en_q;
    logic [3:0]             alu_fun_q;
    logic                   clk_gate_en_q;
    logic [DATAWIDTH-1:0]   fifo_wr_data_q;
    logic                   fifo_wr_inc_q;
    logic [DATAWIDTH-1:0]   rd_data_q;
    logic [2*DATAWIDTH-1:0] alu_out_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q        <= S_IDLE;
            rf_addr_q      <= '0;
            rf_wr_en_q     <= 1'b0;
            rf_rd_en_q     <= 1'b0;
            rf_wr_data_q   <= '0;
            alu_en_q       <= 1'b0;
            alu_fun_q      <= '0;
            clk_gate_en_q  <= 1'b0;
            fifo_wr_data_q <= '0;
            fifo_wr_inc_q  <= 1'b0;
            rd_data_q      <= '0;
            alu_out_q      <= '0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them.
            rf_wr_en_q    <= 1'b0;
            rf_rd_en_q    <= 1'b0;
            fifo_wr_inc_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (bus.RX_D_VLD) begin
                        case (bus.RX_P_DATA)
                            OP_RF_WR:  state_q <= S_WR_ADDR;
                            OP_RF_RD:  state_q <= S_RD_ADDR;
                            OP_ALU_OP: state_q <= S_OPA;
                            OP_ALU_NO: state_q <= S_FUN;
                            default:   state_q <= S_IDLE;
                        endcase
                    end
                end

                S_WR_ADDR: begin
                    if (bus.RX_D_VLD) begin
                        rf_addr_q <= bus.RX_P_DATA[ADDRWIDTH-1:0];
                        state_q   <= S_WR_DATA;
                    end
                end

                S_WR_DATA: begin
                    if (bus.RX_D_VLD) begin
                        rf_wr_en_q   <= 1'b1;
                        rf_wr_data_q <= bus.RX_P_DATA;
                        state_q      <= S_IDLE;
                    end
                end

                S_RD_ADDR: begin
                    if (bus.RX_D_VLD) begin
                        rf_addr_q  <= bus.RX_P_DATA[ADDRWIDTH-1:0];
                        rf_rd_en_q <= 1'b1;
                        state_q    <= S_RD_WAIT;
                    end
                end

                S_RD_WAIT: begin
                    if (bus.RF_RD_VLD) begin
                        rd_data_q <= bus.RF_RD_DATA;
                        state_q   <= S_RD_SEND;
                    end
                end

                S_RD_SEND: begin
                    if (!bus.FIFO_FULL) begin
                        fifo_wr_inc_q  <= 1'b1;
                        fifo_wr_data_q <= rd_data_q;
                        state_q        <= S_IDLE;
                    end
                end

                S_OPA: begin
                    if (bus.RX_D_VLD) begin
                        rf_addr_q    <= OPA_ADDR;
                        rf_wr_data_q <= bus.RX_P_DATA;
                        rf_wr_en_q   <= 1'b1;
                        state_q      <= S_OPB;
                    end
                end

                S_OPB: begin
                    if (bus.RX_D_VLD) begin
                        rf_addr_q    <= OPB_ADDR;
                        rf_wr_data_q <= bus.RX_P_DATA;
                        rf_wr_en_q   <= 1'b1;
                        state_q      <= S_FUN;
                    end
                end

                S_FUN: begin
                    if (bus.RX_D_VLD) begin
                        alu_fun_q     <= bus.RX_P_DATA[3:0];
                        alu_en_q      <= 1'b1;
                        clk_gate_en_q <= 1'b1;
                        state_q       <= S_ALU_WAIT;
                    end
                end

                S_ALU_WAIT: begin
                    if (bus.ALU_OUT_VLD) begin
                        alu_out_q     <= bus.ALU_OUT;
                        alu_en_q      <= 1'b0;
                        clk_gate_en_q <= 1'b0;
                        state_q       <= S_SEND_LO;
                    end
                end

                // FIFO_WR_DATA only changes together with a write, so it stays stable under backpressure.
                S_SEND_LO: begin
                    if (!bus.FIFO_FULL) begin
                        fifo_wr_inc_q  <= 1'b1;
                        fifo_wr_data_q <= alu_out_q[DATAWIDTH-1:0];
                        state_q        <= S_SEND_HI;
                    end
                end

                S_SEND_HI: begin
                    if (!bus.FIFO_FULL) begin
                        fifo_wr_inc_q  <= 1'b1;
                        fifo_wr_data_q <= alu_out_q[2*DATAWIDTH-1:DATAWIDTH];
                        state_q        <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.RF_ADDR      = rf_addr_q;
    assign bus.RF_WR_EN     = rf_wr_en_q;
    assign bus.RF_RD_EN     = rf_rd_en_q;
    assign bus.RF_WR_DATA   = rf_wr_data_q;
    assign bus.ALU_EN       = alu_en_q;
    assign bus.ALU_FUN      = alu_fun_q;
    assign bus.CLK_GATE_EN  = clk_gate_en_q;
    assign bus.FIFO_WR_DATA = fifo_wr_data_q;
    assign bus.FIFO_WR_INC  = fifo_wr_inc_q;

endmodule
